// File: rtl/fp_divider.sv
// Iterative single-precision divider: restoring mantissa division, one quotient
// bit per clock, valid/ready on both sides. Zero-exponent means zero, truncation.
module fp_divider #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W+EXP_W:0]     a,
  input  logic [MANT_W+EXP_W:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANT_W+EXP_W:0]     y,
  output logic                      dz,
  output logic                      ovf,
  output logic                      unf
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int MW = MANT_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MW);
  localparam logic [CW-1:0]    LAST   = CW'(MW - 1);
  localparam logic [EXP_W-1:0] EXP_HI = {EXP_W{1'b1}};
  localparam logic [EW-1:0]    BIAS_W = EW'(BIAS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [MW:0]       rem;
  logic [MW-1:0]     mb;
  logic [MANT_W-1:0] q;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     e;
  logic              sy;

  // operand decode at the input port
  logic [EXP_W-1:0] ea, eb;
  logic [MW-1:0]    ma_in, mb_in;
  logic             special, accept, lt;
  logic [EW-1:0]    e_in;

  assign ea      = a[W-2:MANT_W];
  assign eb      = b[W-2:MANT_W];
  assign ma_in   = {1'b1, a[MANT_W-1:0]};
  assign mb_in   = {1'b1, b[MANT_W-1:0]};
  assign special = (eb == '0) || (ea == '0) || (ea == EXP_HI) || (eb == EXP_HI);
  assign accept  = in_valid && in_ready;
  assign lt      = ma_in < mb_in;
  assign e_in    = {2'b00, ea} - {2'b00, eb} + BIAS_W - {{(EW-1){1'b0}}, lt};

  // restoring step; rem < 2*mb always, so the difference fits in MW bits
  logic              ge;
  logic [MW-1:0]     sub;
  logic [MW:0]       rem_n;
  logic [MANT_W-1:0] q_n;
  logic              e_ovf, e_unf;

  assign ge    = rem >= {1'b0, mb};
  assign sub   = rem[MW-1:0] - mb;
  assign rem_n = {(ge ? sub : rem[MW-1:0]), 1'b0};
  assign q_n   = {q[MANT_W-2:0], ge};
  assign e_unf = e[EW-1] || (e == '0);
  assign e_ovf = !e[EW-1] && (e[EW-2:0] >= {1'b0, EXP_HI});

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = special ? DONE : CALC;
      CALC: if (cnt == LAST) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      mb    <= '0;
      q     <= '0;
      cnt   <= '0;
      e     <= '0;
      sy    <= 1'b0;
      y     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          sy  <= a[W-1] ^ b[W-1];
          mb  <= mb_in;
          rem <= lt ? {ma_in, 1'b0} : {1'b0, ma_in};
          e   <= e_in;
          q   <= '0;
          cnt <= '0;
          dz  <= 1'b0;
          ovf <= 1'b0;
          unf <= 1'b0;
          // special priority: divide-by-zero beats a zero dividend
          if (eb == '0) begin
            y  <= {a[W-1] ^ b[W-1], EXP_HI, {MANT_W{1'b0}}};
            dz <= 1'b1;
          end else if (ea == '0)
            y  <= {a[W-1] ^ b[W-1], {(W-1){1'b0}}};
          else if (ea == EXP_HI)
            y  <= {a[W-1] ^ b[W-1], EXP_HI, {MANT_W{1'b0}}};
          else if (eb == EXP_HI)
            y  <= {a[W-1] ^ b[W-1], {(W-1){1'b0}}};
        end
        CALC: begin
          rem <= rem_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            if (e_ovf) begin
              y   <= {sy, EXP_HI, {MANT_W{1'b0}}};
              ovf <= 1'b1;
            end else if (e_unf) begin
              y   <= {sy, {(W-1){1'b0}}};
              unf <= 1'b1;
            end else
              y   <= {sy, e[EXP_W-1:0], q_n};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
